// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says button front-end.
package simon_pkg;

   localparam int unsigned NUM_BTNS = 4;
   localparam int unsigned COLOUR_W = 2;

   typedef logic [COLOUR_W-1:0] colour_t;

   localparam colour_t COL_0 = 2'd0;
   localparam colour_t COL_1 = 2'd1;
   localparam colour_t COL_2 = 2'd2;
   localparam colour_t COL_3 = 2'd3;

   typedef enum logic [1:0] {
      REL_WAIT = 2'd0,
      ARMED    = 2'd1,
      HELD     = 2'd2
   } state_t;

   // Encode a one-hot button vector into its colour; non-one-hot maps to COL_0.
   function automatic colour_t encode_btn(input logic [NUM_BTNS-1:0] btn);
      colour_t col;
      case (btn)
         NUM_BTNS'(1): col = COL_0;
         NUM_BTNS'(2): col = COL_1;
         NUM_BTNS'(4): col = COL_2;
         NUM_BTNS'(8): col = COL_3;
         default:      col = COL_0;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchroniser followed by a saturating debounce counter.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_stable
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic           sync1;
   logic           sync2;
   logic [CW-1:0]  cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has held for DEBOUNCE_CYCLES synced cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         btn_stable <= 1'b0;
      end else if (sync2 == btn_stable) begin
         cnt <= '0;
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
         btn_stable <= ~btn_stable;
         cnt        <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/colour_button_conditioner.sv
// Colour button conditioner: debounces four buttons and emits one encoded
// valid/ready press event per physical press.
// Optional idle timeout pulse enabled by defining COLOUR_BTN_TIMEOUT_EN.
module colour_button_conditioner
   import simon_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20000,
   parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic                press_valid,
   output colour_t             press_colour,
   input  logic                press_ready,
   output logic [NUM_BTNS-1:0] btn_stable,
   output logic                multi_press_err,
   output logic                overflow,
   output logic                timeout
);

   localparam int unsigned CNT_W = $clog2(NUM_BTNS + 1);

   state_t           state;
   state_t           state_n;
   logic             valid_n;
   colour_t          colour_n;
   logic             err_n;
   logic             ovf_n;
   logic [CNT_W-1:0] n_pressed;

   // Per-button synchroniser and debouncer.
   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw[g]),
         .btn_stable(btn_stable[g])
      );
   end

   assign n_pressed = CNT_W'($countones(btn_stable));

   // Press detection FSM, encoder and event handshake next-state logic.
   always_comb begin
      state_n  = state;
      valid_n  = press_valid & ~press_ready;
      colour_n = press_colour;
      err_n    = 1'b0;
      ovf_n    = overflow;
      if (!en) begin
         state_n = REL_WAIT;
         valid_n = 1'b0;
      end else begin
         case (state)
            REL_WAIT, HELD: begin
               if (btn_stable == '0) state_n = ARMED;
            end
            ARMED: begin
               if (n_pressed == CNT_W'(1)) begin
                  state_n = HELD;
                  if (valid_n) begin
                     ovf_n = 1'b1;
                  end else begin
                     valid_n  = 1'b1;
                     colour_n = encode_btn(btn_stable);
                  end
               end else if (n_pressed > CNT_W'(1)) begin
                  err_n   = 1'b1;
                  state_n = REL_WAIT;
               end
            end
            default: state_n = REL_WAIT;
         endcase
      end
   end

   // FSM state and registered event outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= REL_WAIT;
         press_valid     <= 1'b0;
         press_colour    <= COL_0;
         multi_press_err <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         state           <= state_n;
         press_valid     <= valid_n;
         press_colour    <= colour_n;
         multi_press_err <= err_n;
         overflow        <= ovf_n;
      end
   end

`ifdef COLOUR_BTN_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_n;
   logic          timeout_n;

   // Idle counter: runs only while armed with no event pending.
   always_comb begin
      tcnt_n    = tcnt;
      timeout_n = 1'b0;
      if (!en || state_n != ARMED) begin
         tcnt_n = '0;
      end else if (!press_valid) begin
         if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
            tcnt_n    = '0;
            timeout_n = 1'b1;
         end else begin
            tcnt_n = tcnt + TW'(1);
         end
      end
   end

   // Timeout counter and pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         tcnt    <= tcnt_n;
         timeout <= timeout_n;
      end
   end
`else
   // Feature absent: timeout is constant low; the parameter is kept for a uniform interface.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_colour_button_conditioner.sv
// Self-checking bench for colour_button_conditioner with a behavioural model.
module tb_colour_button_conditioner;

   localparam int unsigned DB = 4;
   localparam int unsigned TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] btn_raw;
   logic       press_valid;
   logic [1:0] press_colour;
   logic       press_ready;
   logic [3:0] btn_stable;
   logic       multi_press_err;
   logic       overflow;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // Behavioural model: synchroniser pipe, per-bit run lengths, "armed" flag, pending event.
   logic [3:0] m_s1, m_s2, m_stab;
   int         m_run [4];
   bit         m_armed, m_valid, m_err, m_ovf, m_tmo;
   logic [1:0] m_col;
   int         m_tcnt;

   colour_button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .btn_raw        (btn_raw),
      .press_valid    (press_valid),
      .press_colour   (press_colour),
      .press_ready    (press_ready),
      .btn_stable     (btn_stable),
      .multi_press_err(multi_press_err),
      .overflow       (overflow),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t required earlier end", $time);
      $fatal(1);
   end

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stab = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_armed = 0; m_valid = 0; m_err = 0; m_ovf = 0; m_tmo = 0;
      m_col = '0; m_tcnt = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      int npress;
      int idx;
      bit valid_old;
      valid_old = m_valid;
      npress = 0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (m_stab[i]) begin npress++; idx = i; end
      m_err = 0;
      if (!en) begin
         m_armed = 0;
         m_valid = 0;
      end else begin
         m_valid = m_valid && !press_ready;
         if (!m_armed) begin
            if (m_stab == 4'd0) m_armed = 1;
         end else if (npress == 1) begin
            m_armed = 0;
            if (m_valid) m_ovf = 1;
            else begin m_valid = 1; m_col = 2'(idx); end
         end else if (npress >= 2) begin
            m_err = 1;
            m_armed = 0;
         end
      end
      m_tmo = 0;
`ifdef COLOUR_BTN_TIMEOUT_EN
      if (!en || !m_armed) m_tcnt = 0;
      else if (!valid_old) begin
         if (m_tcnt == TO - 1) begin m_tmo = 1; m_tcnt = 0; end
         else m_tcnt++;
      end
`endif
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] == m_stab[i]) m_run[i] = 0;
         else begin
            m_run[i]++;
            if (m_run[i] == DB) begin m_stab[i] = ~m_stab[i]; m_run[i] = 0; end
         end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
   endtask

   // One clock: update model, pass the rising edge, return at the falling edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      btn_raw = 4'd0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      btn_raw = 4'd0;
      en = 1'b1;
      press_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; en = 1'b1; press_ready = 1'b1; btn_raw = 4'd0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", press_valid); end
      total++; if (btn_stable !== 4'd0) begin bad++; $display("FAIL reset_stable got=%b exp=0000", btn_stable); end
      total++; if ({press_colour, multi_press_err, overflow, timeout} !== 5'd0)
         begin bad++; $display("FAIL reset_misc got=%b exp=00000", {press_colour, multi_press_err, overflow, timeout}); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int k;
      idle(12);
      btn_raw = 4'b0100;
      for (int e = 0; e <= 4; e++) step();
      total++; if (btn_stable !== 4'd0) begin bad++; $display("FAIL basic_stable_early got=%b exp=0000", btn_stable); end
      step();
      total++; if (btn_stable !== 4'b0100) begin bad++; $display("FAIL basic_stable_edge5 got=%b exp=0100", btn_stable); end
      total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_edge5 got=%b exp=0", press_valid); end
      step();
      total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_edge6 got=%b exp=1", press_valid); end
      total++; if (press_colour !== 2'd2) begin bad++; $display("FAIL basic_colour got=%0d exp=2", press_colour); end
      step();
      total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_edge7 got=%b exp=0", press_valid); end
      idle(12);
      btn_raw = 4'b0001;
      k = 0;
      while (press_valid !== 1'b1 && k < 20) begin step(); k++; end
      total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL basic2_valid got=%b exp=1", press_valid); end
      total++; if (press_colour !== 2'd0) begin bad++; $display("FAIL basic2_colour got=%0d exp=0", press_colour); end
      idle(12);
   endtask

   task automatic test_glitch();
      int errs;
      int k;
      errs = 0;
      btn_raw = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step();
         if (btn_stable !== 4'd0 || press_valid !== 1'b0) errs++;
      end
      btn_raw = 4'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (btn_stable !== 4'd0 || press_valid !== 1'b0) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL glitch_ignored got=%0d bad cycles exp=0", errs); end
      btn_raw = 4'b0010;
      k = 0;
      while (press_valid !== 1'b1 && k < 20) begin step(); k++; end
      total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL glitch_hold_valid got=%b exp=1", press_valid); end
      total++; if (press_colour !== 2'd1) begin bad++; $display("FAIL glitch_hold_colour got=%0d exp=1", press_colour); end
      idle(12);
   endtask

   task automatic test_multi();
      int errs, valids, k;
      errs = 0; valids = 0;
      btn_raw = 4'b1001;
      for (int i = 0; i < 15; i++) begin
         step();
         if (multi_press_err === 1'b1) errs++;
         if (press_valid === 1'b1) valids++;
      end
      total++; if (errs != 1) begin bad++; $display("FAIL multi_err_pulses got=%0d exp=1", errs); end
      total++; if (valids != 0) begin bad++; $display("FAIL multi_no_event got=%0d exp=0", valids); end
      idle(12);
      btn_raw = 4'b1000;
      k = 0;
      while (press_valid !== 1'b1 && k < 20) begin step(); k++; end
      total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL multi_single_valid got=%b exp=1", press_valid); end
      total++; if (press_colour !== 2'd3) begin bad++; $display("FAIL multi_single_colour got=%0d exp=3", press_colour); end
      idle(12);
   endtask

   task automatic test_overflow();
      int k;
      press_ready = 1'b0;
      btn_raw = 4'b0010;
      k = 0;
      while (press_valid !== 1'b1 && k < 20) begin step(); k++; end
      total++; if (press_colour !== 2'd1) begin bad++; $display("FAIL ovf_first_colour got=%0d exp=1", press_colour); end
      idle(12);
      btn_raw = 4'b1000;
      for (int i = 0; i < 12; i++) step();
      total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid_held got=%b exp=1", press_valid); end
      total++; if (press_colour !== 2'd1) begin bad++; $display("FAIL ovf_colour_frozen got=%0d exp=1", press_colour); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      press_ready = 1'b1;
      step();
      total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL ovf_accept_clear got=%b exp=0", press_valid); end
      idle(12);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_async_reset();
      int k;
      btn_raw = 4'b0100;
      k = 0;
      while (btn_stable !== 4'b0100 && k < 20) begin step(); k++; end
      step(); step();
      btn_raw = 4'd0;
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (btn_stable !== 4'd0) begin bad++; $display("FAIL areset_stable got=%b exp=0000", btn_stable); end
      total++; if ({press_valid, press_colour, multi_press_err, overflow, timeout} !== 6'd0)
         begin bad++; $display("FAIL areset_outputs got=%b exp=000000", {press_valid, press_colour, multi_press_err, overflow, timeout}); end
      @(negedge clk);
      btn_raw = 4'b0010;
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e <= 4; e++) step();
      total++; if (btn_stable !== 4'd0) begin bad++; $display("FAIL areset_full_debounce got=%b exp=0000", btn_stable); end
      step();
      total++; if (btn_stable !== 4'b0010) begin bad++; $display("FAIL areset_stable_edge5 got=%b exp=0010", btn_stable); end
      step();
      total++; if (press_valid !== 1'b1 || press_colour !== 2'd1)
         begin bad++; $display("FAIL areset_event got=%b/%0d exp=1/1", press_valid, press_colour); end
      idle(12);
   endtask

   task automatic test_en();
      int errs, k;
      errs = 0;
      en = 1'b0;
      btn_raw = 4'b0100;
      for (int i = 0; i < 12; i++) begin step(); if (press_valid !== 1'b0) errs++; end
      total++; if (btn_stable !== 4'b0100) begin bad++; $display("FAIL en_debounce_runs got=%b exp=0100", btn_stable); end
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); if (press_valid !== 1'b0) errs++; end
      total++; if (errs != 0) begin bad++; $display("FAIL en_held_no_event got=%0d exp=0", errs); end
      idle(12);
      btn_raw = 4'b0100;
      k = 0;
      while (press_valid !== 1'b1 && k < 20) begin step(); k++; end
      total++; if (press_valid !== 1'b1 || press_colour !== 2'd2)
         begin bad++; $display("FAIL en_repress got=%b/%0d exp=1/2", press_valid, press_colour); end
      idle(12);
   endtask

   task automatic test_timeout();
      int pulses, first, second, diffs;
      pulses = 0; first = -1; second = -1; diffs = 0;
      btn_raw = 4'd0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (timeout !== 1'(m_tmo)) diffs++;
         if (timeout === 1'b1) begin
            pulses++;
            if (first < 0) first = i; else if (second < 0) second = i;
         end
      end
      total++; if (diffs != 0) begin bad++; $display("FAIL timeout_model got=%0d diff cycles exp=0", diffs); end
`ifdef COLOUR_BTN_TIMEOUT_EN
      total++; if (second - first != int'(TO)) begin bad++; $display("FAIL timeout_period got=%0d exp=%0d", second - first, TO); end
      pulses = 0;
      for (int i = 0; i < 10; i++) step();
      btn_raw = 4'b0001;
      for (int i = 0; i < 30; i++) begin step(); if (timeout === 1'b1) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL timeout_press_blocks got=%0d exp=0", pulses); end
`else
      total++; if (pulses != 0) begin bad++; $display("FAIL timeout_tied got=%0d pulses exp=0 (first=%0d second=%0d)", pulses, first, second); end
`endif
      idle(12);
   endtask

   task automatic test_random();
      logic [9:0] got, exp;
      int shown;
      shown = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0, 1: btn_raw = 4'd0;
               2:    btn_raw = 4'(1 << $urandom_range(0, 3));
               default: btn_raw = 4'($urandom_range(0, 15));
            endcase
         end
         press_ready = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 99) != 0);
         step();
         got = {press_valid, press_colour, btn_stable, multi_press_err, overflow, timeout};
         exp = {m_valid, m_col, m_stab, m_err, m_ovf, m_tmo};
         total++;
         if (got !== exp) begin
            bad++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random cycle %0d {valid,colour,stable,err,ovf,tmo} got=%b exp=%b", c, got, exp);
            end
         end
      end
      en = 1'b1;
      press_ready = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_glitch();
      test_multi();
      test_overflow();
      test_async_reset();
      test_en();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
